dds_multichan: RTL and testbench

//  Parametrised multi-channel DDS; successor to the single-channel ring DDS.
//  - NCH independent phase accumulators share one sample-rate divider.
//  - Per channel: waveform mode (saw/triangle/square/DC), phase offset, duty, enable.
//  - Configured over the existing 16-bit wr/waddr/wdata register bus; shadow registers with commit give glitch-free retune.

---
 rtl/dds_multichan.sv | 238 +++++++++++++++++++++++
 tb/tb_dds_multichan.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multichan.sv
// ---------------------------------------------------------------------------------------------
// dds_multichan
//   Multi-channel direct digital synthesiser. NCH phase accumulators advance together on a
//   shared sample-rate tick. Each channel produces a saw, triangle, square or DC sample from
//   its accumulated phase plus a per-channel offset. The per-channel settings sit in shadow
//   registers written over a 16-bit register bus. At the next tick after a commit they are
//   copied into the active set, so a retune never lands half-way through a sample.
//
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   wr_i         register write strobe (one write per cycle)
//   waddr_i      register address
//   wdata_i      register write data
//   dout_o       samples, channel c at [c*DOUT_W +: DOUT_W]
//   out_valid_o  one-cycle pulse: dout_o was updated this cycle
//
// Register map
//   0x00          CTRL  b0 run, b1 commit (self-clear), b2 phase_clr (self-clear)
//   0x02          DIV   tick every DIV+1 clocks
//   0x20+0x10*c   +0 FREQ_LO, +1 FREQ_HI, +2 POFS, +3 MODE (b1:0 wave, b2 enable), +4 DUTY
// ---------------------------------------------------------------------------------------------
module dds_multichan #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned PHASE_W     = 24,
   parameter int unsigned DOUT_W      = 6,
   parameter bit          AUTO_COMMIT = 1'b0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_i,
   input  logic [15:0]           waddr_i,
   input  logic [15:0]           wdata_i,
   output logic [NCH*DOUT_W-1:0] dout_o,
   output logic                  out_valid_o
);

   localparam int unsigned PofsShift = PHASE_W - 16;

   logic           ctrl_we;
   logic           div_we;
   logic [NCH-1:0] ch_we;
   logic           shadow_we;
   logic           tick;

   logic           run_q, run_d;
   logic [15:0]    div_q, div_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           commit_pend_q, commit_pend_d;
   logic           clr_pend_q, clr_pend_d;
   logic           out_valid_q;

   assign ctrl_we   = wr_i && (waddr_i == 16'h0000);
   assign div_we    = wr_i && (waddr_i == 16'h0002);
   assign shadow_we = |ch_we;
   assign tick      = run_q && (cnt_q == div_q);

   // ------------------------------------------------------------------------------------------
   // Global control: run flag, divider, pending commit / phase clear
   // ------------------------------------------------------------------------------------------
   always_comb begin
      run_d         = run_q;
      div_d         = div_q;
      cnt_d         = cnt_q;
      commit_pend_d = commit_pend_q;
      clr_pend_d    = clr_pend_q;

      if (ctrl_we) begin
         run_d = wdata_i[0];
      end
      if (div_we) begin
         div_d = wdata_i;
      end

      if (div_we) begin
         cnt_d = '0;
      end else if (run_q) begin
         cnt_d = tick ? '0 : cnt_q + 16'd1;
      end

      // A request arriving in the tick cycle must survive that tick's clear; it belongs to
      // the following tick.
      commit_pend_d = (commit_pend_q && !tick) || (ctrl_we && wdata_i[1]) ||
                      (AUTO_COMMIT && shadow_we);
      clr_pend_d    = (clr_pend_q && !tick) || (ctrl_we && wdata_i[2]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q         <= 1'b1;
         div_q         <= '0;
         cnt_q         <= '0;
         commit_pend_q <= 1'b0;
         clr_pend_q    <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         run_q         <= run_d;
         div_q         <= div_d;
         cnt_q         <= cnt_d;
         commit_pend_q <= commit_pend_d;
         clr_pend_q    <= clr_pend_d;
         out_valid_q   <= tick;
      end
   end

   assign out_valid_o = out_valid_q;

   // ------------------------------------------------------------------------------------------
   // Per-channel shadow/active registers, accumulator and waveform generator
   // ------------------------------------------------------------------------------------------
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      localparam logic [3:0] ChNib = 4'(c + 2);

      logic [15:0]         flo_q, flo_d;
      logic [15:0]         fhi_q, fhi_d;
      logic [15:0]         pofs_q, pofs_d;
      logic [2:0]          mode_q, mode_d;
      logic [15:0]         duty_q, duty_d;

      logic [PHASE_W-1:0]  freq_act_q, freq_act_d;
      logic [15:0]         pofs_act_q, pofs_act_d;
      logic [2:0]          mode_act_q, mode_act_d;
      logic [15:0]         duty_act_q, duty_act_d;

      logic [PHASE_W-1:0]  acc_q, acc_d;
      logic [DOUT_W-1:0]   samp_q, samp_d;

      logic [PHASE_W-1:0]  freq_sh;
      logic [PHASE_W-1:0]  freq_e;
      logic [15:0]         pofs_e;
      logic [2:0]          mode_e;
      logic [15:0]         duty_e;
      logic [PHASE_W-1:0]  acc_n;
      logic [PHASE_W-1:0]  phase;
      logic [PHASE_W-1:0]  tri_src;
      logic [15:0]         t_top;
      logic [DOUT_W-1:0]   wave;

      assign ch_we[c] = wr_i && (waddr_i[15:8] == 8'h00) && (waddr_i[7:4] == ChNib) &&
                        (waddr_i[3:0] <= 4'd4);

      assign freq_sh = PHASE_W'({fhi_q, flo_q});

      // Shadow register writes
      always_comb begin
         flo_d  = flo_q;
         fhi_d  = fhi_q;
         pofs_d = pofs_q;
         mode_d = mode_q;
         duty_d = duty_q;
         if (ch_we[c]) begin
            unique case (waddr_i[3:0])
               4'd0:    flo_d  = wdata_i;
               4'd1:    fhi_d  = wdata_i;
               4'd2:    pofs_d = wdata_i;
               4'd3:    mode_d = wdata_i[2:0];
               4'd4:    duty_d = wdata_i;
               default: ;
            endcase
         end
      end

      // On a committing tick the shadow values drive this very sample, so new settings show
      // up on the first out_valid after the commit takes effect.
      always_comb begin
         freq_e  = commit_pend_q ? freq_sh : freq_act_q;
         pofs_e  = commit_pend_q ? pofs_q  : pofs_act_q;
         mode_e  = commit_pend_q ? mode_q  : mode_act_q;
         duty_e  = commit_pend_q ? duty_q  : duty_act_q;

         if (!mode_e[2] || clr_pend_q) begin
            acc_n = '0;
         end else begin
            acc_n = acc_q + freq_e;
         end

         phase   = acc_n + (PHASE_W'(pofs_e) << PofsShift);
         t_top   = phase[PHASE_W-1 -: 16];
         // Drop the MSB and take the next DOUT_W bits; the shift keeps the slice in range
         // even when DOUT_W reaches PHASE_W-1.
         tri_src = phase << 1;

         unique case (mode_e[1:0])
            2'd0:    wave = phase[PHASE_W-1 -: DOUT_W];
            2'd1:    wave = phase[PHASE_W-1] ? ~tri_src[PHASE_W-1 -: DOUT_W]
                                              :  tri_src[PHASE_W-1 -: DOUT_W];
            2'd2:    wave = (t_top < duty_e) ? {DOUT_W{1'b1}} : '0;
            default: wave = duty_e[15 -: DOUT_W];
         endcase

         freq_act_d = freq_act_q;
         pofs_act_d = pofs_act_q;
         mode_act_d = mode_act_q;
         duty_act_d = duty_act_q;
         acc_d      = acc_q;
         samp_d     = samp_q;
         if (tick) begin
            freq_act_d = freq_e;
            pofs_act_d = pofs_e;
            mode_act_d = mode_e;
            duty_act_d = duty_e;
            acc_d      = acc_n;
            samp_d     = mode_e[2] ? wave : '0;
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            flo_q      <= '0;
            fhi_q      <= '0;
            pofs_q     <= '0;
            mode_q     <= 3'b100;
            duty_q     <= 16'h8000;
            freq_act_q <= '0;
            pofs_act_q <= '0;
            mode_act_q <= 3'b100;
            duty_act_q <= 16'h8000;
            acc_q      <= '0;
            samp_q     <= '0;
         end else begin
            flo_q      <= flo_d;
            fhi_q      <= fhi_d;
            pofs_q     <= pofs_d;
            mode_q     <= mode_d;
            duty_q     <= duty_d;
            freq_act_q <= freq_act_d;
            pofs_act_q <= pofs_act_d;
            mode_act_q <= mode_act_d;
            duty_act_q <= duty_act_d;
            acc_q      <= acc_d;
            samp_q     <= samp_d;
         end
      end

      assign dout_o[c*DOUT_W +: DOUT_W] = samp_q;
   end

endmodule

// File: tb/tb_dds_multichan.sv
// ---------------------------------------------------------------------------------------------
// tb_dds_multichan
//   Bench for dds_multichan with NCH=2, PHASE_W=16, DOUT_W=6, AUTO_COMMIT=0. A reference
//   model follows the register bus at every rising edge and queues the expected sample word
//   for each tick. A checker compares out_valid every cycle, pops the queue on each
//   out_valid and otherwise requires dout to hold. Directed checks add waveform-shape,
//   period, latency and reset properties.
// ---------------------------------------------------------------------------------------------
module tb_dds_multichan;

   localparam int unsigned Nch = 2;
   localparam int unsigned Dw  = 6;
   localparam int unsigned Ww  = Nch * Dw;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          wr   = 1'b0;
   logic [15:0]   waddr = '0;
   logic [15:0]   wdata = '0;
   logic [Ww-1:0] dout;
   logic          out_valid;

   int n_chk = 0;
   int n_bad = 0;

   dds_multichan #(
      .NCH        (Nch),
      .PHASE_W    (16),
      .DOUT_W     (Dw),
      .AUTO_COMMIT(1'b0)
   ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .wr_i       (wr),
      .waddr_i    (waddr),
      .wdata_i    (wdata),
      .dout_o     (dout),
      .out_valid_o(out_valid)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- reference model state
   logic [15:0]   m_flo [Nch];
   logic [15:0]   m_fhi [Nch];
   logic [15:0]   m_pofs[Nch];
   logic [2:0]    m_mode[Nch];
   logic [15:0]   m_duty[Nch];
   logic [15:0]   a_freq[Nch];
   logic [15:0]   a_pofs[Nch];
   logic [2:0]    a_mode[Nch];
   logic [15:0]   a_duty[Nch];
   logic [15:0]   m_acc [Nch];
   logic          m_run, m_cpend, m_clr, m_vld;
   logic [15:0]   m_div, m_cnt;
   logic [Ww-1:0] exp_q[$];
   logic [Ww-1:0] last;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] wave(input logic [15:0] p, input logic [1:0] w,
                                       input logic [15:0] duty);
      logic [5:0] f;
      f = p[14:9];
      case (w)
         2'd0:    return p[15:10];
         2'd1:    return p[15] ? ~f : f;
         2'd2:    return (p < duty) ? 6'h3f : 6'h00;
         default: return duty[15:10];
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < Nch; c++) begin
         m_flo[c] = '0; m_fhi[c] = '0; m_pofs[c] = '0; m_mode[c] = 3'b100;
         m_duty[c] = 16'h8000;
         a_freq[c] = '0; a_pofs[c] = '0; a_mode[c] = 3'b100; a_duty[c] = 16'h8000;
         m_acc[c] = '0;
      end
      m_run = 1'b1; m_cpend = 1'b0; m_clr = 1'b0; m_vld = 1'b0;
      m_div = '0; m_cnt = '0;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic          tk;
      logic [Ww-1:0] word;
      int            c;
      tk = m_run && (m_cnt == m_div);
      if (tk) begin
         word = '0;
         for (int k = 0; k < Nch; k++) begin
            if (m_cpend) begin
               a_freq[k] = m_fhi[k] & 16'h0 | m_flo[k];
               a_pofs[k] = m_pofs[k]; a_mode[k] = m_mode[k]; a_duty[k] = m_duty[k];
            end
            if (!a_mode[k][2]) begin
               m_acc[k] = '0;
            end else begin
               m_acc[k] = m_clr ? 16'h0 : m_acc[k] + a_freq[k];
               word[k*Dw +: Dw] = wave(m_acc[k] + a_pofs[k], a_mode[k][1:0], a_duty[k]);
            end
         end
         exp_q.push_back(word);
         m_cpend = 1'b0;
         m_clr   = 1'b0;
      end
      m_vld = tk;
      if (wr && waddr == 16'h0002) m_cnt = '0;
      else if (m_run)              m_cnt = tk ? 16'h0 : m_cnt + 16'd1;
      if (wr) begin
         if (waddr == 16'h0000) begin
            m_run = wdata[0];
            if (wdata[1]) m_cpend = 1'b1;
            if (wdata[2]) m_clr = 1'b1;
         end else if (waddr == 16'h0002) begin
            m_div = wdata;
         end else if (waddr[15:8] == 8'h00 && waddr[7:4] >= 4'd2 && waddr[7:4] <= 4'd3 &&
                      waddr[3:0] <= 4'd4) begin
            c = int'(waddr[7:4]) - 2;
            case (waddr[3:0])
               4'd0:    m_flo[c]  = wdata;
               4'd1:    m_fhi[c]  = wdata;
               4'd2:    m_pofs[c] = wdata;
               4'd3:    m_mode[c] = wdata[2:0];
               default: m_duty[c] = wdata;
            endcase
         end
      end
   endtask

   // ---------------------------------------------------------------- stimulus helpers
   // Drive one write in the current cycle (caller is at a falling edge).
   task automatic drive(input logic [15:0] a, input logic [15:0] d);
      wr = 1'b1; waddr = a; wdata = d;
      @(negedge clk);
      wr = 1'b0; waddr = '0; wdata = '0;
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      drive(a, d);
   endtask

   task automatic wait_valid(output logic [Ww-1:0] d);
      d = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) begin
            d = dout;
            return;
         end
      end
      check_eq("valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic skip_valid(input int n);
      logic [Ww-1:0] d;
      for (int i = 0; i < n; i++) wait_valid(d);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      logic [Ww-1:0] d;
      logic [63:0]   seen;
      int            cnt, cnt2, lat;

      model_reset();
      last = '0;

      fork
         forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else       model_step();
         end
         forever begin
            @(negedge clk);
            if (!rstn) last = '0;
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
            if (out_valid) begin
               check_eq("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  last = exp_q.pop_front();
                  check_eq("sample", 32'(dout), 32'(last));
               end
            end else begin
               check_eq("hold", 32'(dout), 32'(last));
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      rstn = 1'b1;

      // 1: ch0 saw ramp, ch1 idle
      wr_reg(16'h0020, 16'h0400);
      wr_reg(16'h0000, 16'h0003);
      skip_valid(5);
      seen = '0; cnt = 0;
      for (int i = 0; i < 64; i++) begin
         wait_valid(d);
         seen[d[5:0]] = 1'b1;
         if (d[11:6] != 6'd0) cnt++;
      end
      check_eq("saw_cover_lo", seen[31:0], 32'hffff_ffff);
      check_eq("saw_cover_hi", seen[63:32], 32'hffff_ffff);
      check_eq("ch1_idle", cnt, 0);

      // 2: ch1 half a cycle ahead after a phase clear
      wr_reg(16'h0030, 16'h0400);
      wr_reg(16'h0032, 16'h8000);
      wr_reg(16'h0000, 16'h0007);
      skip_valid(2);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         wait_valid(d);
         if (d[11:6] != 6'(d[5:0] + 6'd32)) cnt++;
      end
      check_eq("ch1_offset", cnt, 0);

      // 3: triangle covers every level once per period; square and DC
      wr_reg(16'h0023, 16'h0005);
      wr_reg(16'h0000, 16'h0003);
      skip_valid(2);
      seen = '0;
      for (int i = 0; i < 64; i++) begin
         wait_valid(d);
         seen[d[5:0]] = 1'b1;
      end
      check_eq("tri_cover_lo", seen[31:0], 32'hffff_ffff);
      check_eq("tri_cover_hi", seen[63:32], 32'hffff_ffff);

      wr_reg(16'h0024, 16'h4000);
      wr_reg(16'h0023, 16'h0006);
      wr_reg(16'h0000, 16'h0003);
      skip_valid(2);
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 64; i++) begin
         wait_valid(d);
         if (d[5:0] == 6'h3f) cnt++;
         if (d[5:0] == 6'h00) cnt2++;
      end
      check_eq("sq_high", cnt, 16);
      check_eq("sq_low", cnt2, 48);

      wr_reg(16'h0024, 16'ha000);
      wr_reg(16'h0023, 16'h0007);
      wr_reg(16'h0000, 16'h0003);
      skip_valid(2);
      wait_valid(d);
      check_eq("dc_level", 32'(d[5:0]), 32'd40);

      // 4: divider period, run=0 hold, resume
      wr_reg(16'h0023, 16'h0004);
      wr_reg(16'h0000, 16'h0003);
      wr_reg(16'h0002, 16'h0003);
      skip_valid(1);
      for (int k = 0; k < 3; k++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!out_valid && cnt < 20);
         check_eq("div_period", cnt, 4);
      end
      wr_reg(16'h0000, 16'h0000);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check_eq("stopped_valids", cnt, 0);
      wr_reg(16'h0000, 16'h0001);
      skip_valid(3);

      // 5: uncommitted write, ignored addresses, commit latency, write in the tick cycle
      wr_reg(16'h0020, 16'h0800);
      wr_reg(16'h0040, 16'hffff);
      wr_reg(16'h0025, 16'h1234);
      wr_reg(16'h0001, 16'h0007);
      skip_valid(3);
      wr_reg(16'h0000, 16'h0003);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check_eq("commit_latency", {31'd0, lat <= 4}, 32'd1);
      skip_valid(2);
      wait_valid(d);
      drive(16'h0020, 16'h0400);
      drive(16'h0000, 16'h0003);
      @(negedge clk);
      drive(16'h0020, 16'h0c00);
      skip_valid(4);

      // 6: reset with a commit pending
      wr_reg(16'h0020, 16'h2000);
      wr_reg(16'h0000, 16'h0003);
      #2 rstn = 1'b0;
      #1;
      check_eq("rst_mid_dout", 32'(dout), 32'd0);
      check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      wait_valid(d);
      check_eq("post_rst_first", 32'(d), 32'd0);
      wr_reg(16'h0030, 16'h0400);
      skip_valid(3);
      wait_valid(d);
      check_eq("post_rst_samples", 32'(d), 32'd0);
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
